// File: rtl/uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_responder
// Description : Host-link command endpoint. Decodes one-byte reads and
//               two-byte writes from the UART receive side into a small
//               configuration register file and answers every command with
//               exactly one reply byte through the UART transmit handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_responder #(
  parameter int          TIMEOUT_CLKS = 100000,
  parameter logic [7:0]  DEVICE_ID    = 8'h45
) (
  input  logic        i_sys_clk,
  input  logic        i_rstn,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  input  logic        i_Tx_Done,
  input  logic [7:0]  i_status,
  output logic [7:0]  o_trig_chan,
  output logic [7:0]  o_trig_type,
  output logic [15:0] o_precap_depth,
  output logic [7:0]  o_clk_div,
  output logic        o_enable,
  output logic        o_start
);

  localparam int            C_CW       = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [C_CW-1:0] C_CNT_LAST = C_CW'(TIMEOUT_CLKS - 1);
  localparam logic [C_CW-1:0] C_CNT_MAX  = '1;
  localparam logic [7:0]    C_ACK      = 8'h06;
  localparam logic [7:0]    C_NAK      = 8'hEE;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DATA = 2'd1,
    S_SEND      = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        addr_q, addr_d;
  logic [C_CW-1:0]   cnt_q, cnt_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              start_q, start_d;
  logic [7:0]        chan_q, chan_d;
  logic [7:0]        type_q, type_d;
  logic [7:0]        depth_lo_q, depth_lo_d;
  logic [7:0]        depth_hi_q, depth_hi_d;
  logic [7:0]        div_q, div_d;
  logic              enable_q, enable_d;

  logic              w_cmd_valid;
  logic [7:0]        w_rd_data;
  logic [C_CW-1:0]   w_cnt_inc;

  // Reserved bits 6:3 must be clear; the counter saturates instead of wrapping.
  assign w_cmd_valid = (i_Rx_Byte[6:3] == 4'b0000);
  assign w_cnt_inc   = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Read-data mux, addressed directly by the incoming command byte.
  always_comb begin
    w_rd_data = 8'h00;
    case (i_Rx_Byte[2:0])
      3'd0:    w_rd_data = chan_q;
      3'd1:    w_rd_data = type_q;
      3'd2:    w_rd_data = depth_lo_q;
      3'd3:    w_rd_data = depth_hi_q;
      3'd4:    w_rd_data = div_q;
      3'd5:    w_rd_data = {7'b0, enable_q};
      3'd6:    w_rd_data = i_status;
      default: w_rd_data = DEVICE_ID;
    endcase
  end

  // Next-state logic for the command FSM and the register file.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    tx_dv_d    = 1'b0;
    tx_byte_d  = tx_byte_q;
    start_d    = 1'b0;
    chan_d     = chan_q;
    type_d     = type_q;
    depth_lo_d = depth_lo_q;
    depth_hi_d = depth_hi_q;
    div_d      = div_q;
    enable_d   = enable_q;
    case (state_q)
      S_IDLE: begin
        if (i_Rx_DV) begin
          if (!w_cmd_valid) begin
            // Invalid bytes never wait for data, even with bit 7 set.
            tx_byte_d = C_NAK;
            state_d   = S_SEND;
          end else if (i_Rx_Byte[7]) begin
            addr_d  = i_Rx_Byte[2:0];
            cnt_d   = '0;
            state_d = S_WAIT_DATA;
          end else begin
            tx_byte_d = w_rd_data;
            state_d   = S_SEND;
          end
        end
      end
      S_WAIT_DATA: begin
        if (i_Rx_DV) begin
          case (addr_q)
            3'd0: chan_d     = i_Rx_Byte;
            3'd1: type_d     = i_Rx_Byte;
            3'd2: depth_lo_d = i_Rx_Byte;
            3'd3: depth_hi_d = i_Rx_Byte;
            3'd4: div_d      = i_Rx_Byte;
            3'd5: begin
              enable_d = i_Rx_Byte[0];
              start_d  = i_Rx_Byte[1];
            end
            default: ;  // status / ID are read-only; write is just acknowledged
          endcase
          tx_byte_d = C_ACK;
          state_d   = S_SEND;
        end else begin
          cnt_d = w_cnt_inc;
          // Abandon silently so a late byte is parsed as a fresh command.
          if (w_cnt_inc >= C_CNT_LAST) begin
            state_d = S_IDLE;
          end
        end
      end
      S_SEND: begin
        tx_dv_d = 1'b1;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // Rx bytes here are dropped; the host must wait for the reply.
        if (i_Tx_Done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and register flops; async reset abandons any pending reply.
  always_ff @(posedge i_sys_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      addr_q     <= 3'd0;
      cnt_q      <= '0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
      start_q    <= 1'b0;
      chan_q     <= 8'h00;
      type_q     <= 8'h00;
      depth_lo_q <= 8'h00;
      depth_hi_q <= 8'h00;
      div_q      <= 8'h00;
      enable_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      start_q    <= start_d;
      chan_q     <= chan_d;
      type_q     <= type_d;
      depth_lo_q <= depth_lo_d;
      depth_hi_q <= depth_hi_d;
      div_q      <= div_d;
      enable_q   <= enable_d;
    end
  end

  assign o_Tx_DV        = tx_dv_q;
  assign o_Tx_Byte      = tx_byte_q;
  assign o_start        = start_q;
  assign o_trig_chan    = chan_q;
  assign o_trig_type    = type_q;
  assign o_precap_depth = {depth_hi_q, depth_lo_q};
  assign o_clk_div      = div_q;
  assign o_enable       = enable_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_responder
// Description : Directed self-checking bench for uart_cmd_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_responder;

  localparam int T = 50;

  logic        clk = 1'b0;
  logic        i_rstn;
  logic        i_Rx_DV;
  logic [7:0]  i_Rx_Byte;
  logic        o_Tx_DV;
  logic [7:0]  o_Tx_Byte;
  logic        i_Tx_Done;
  logic [7:0]  i_status;
  logic [7:0]  o_trig_chan;
  logic [7:0]  o_trig_type;
  logic [15:0] o_precap_depth;
  logic [7:0]  o_clk_div;
  logic        o_enable;
  logic        o_start;

  logic [40:0] regs_v;
  logic [50:0] outs_v;
  assign regs_v = {o_trig_chan, o_trig_type, o_precap_depth, o_clk_div, o_enable};
  assign outs_v = {regs_v, o_start, o_Tx_DV, o_Tx_Byte};

  uart_cmd_responder #(.TIMEOUT_CLKS(T), .DEVICE_ID(8'h45)) dut (
    .i_sys_clk     (clk),
    .i_rstn        (i_rstn),
    .i_Rx_DV       (i_Rx_DV),
    .i_Rx_Byte     (i_Rx_Byte),
    .o_Tx_DV       (o_Tx_DV),
    .o_Tx_Byte     (o_Tx_Byte),
    .i_Tx_Done     (i_Tx_Done),
    .i_status      (i_status),
    .o_trig_chan   (o_trig_chan),
    .o_trig_type   (o_trig_type),
    .o_precap_depth(o_precap_depth),
    .o_clk_div     (o_clk_div),
    .o_enable      (o_enable),
    .o_start       (o_start)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Monitor: counts reply and start pulses, sampled on the falling edge.
  int         tx_pulses = 0;
  int         last_tx_cyc = -1;
  logic [7:0] last_tx_byte = 8'h00;
  logic       prev_dv = 1'b0;
  int         b2b = 0;
  int         start_pulses = 0;
  int         last_start_cyc = -1;
  always @(negedge clk) begin
    if (o_Tx_DV === 1'b1) begin
      tx_pulses++;
      last_tx_cyc  = cyc;
      last_tx_byte = o_Tx_Byte;
      if (prev_dv === 1'b1) b2b++;
    end
    prev_dv = o_Tx_DV;
    if (o_start === 1'b1) begin
      start_pulses++;
      last_start_cyc = cyc;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int rx_cyc = 0;
  int p0;
  int s0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rx(input logic [7:0] b);
    @(negedge clk);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    rx_cyc    = cyc;
    @(negedge clk);
    i_Rx_DV   = 1'b0;
    i_Rx_Byte = 8'h00;
  endtask

  task automatic tx_done();
    @(negedge clk);
    i_Tx_Done = 1'b1;
    @(negedge clk);
    i_Tx_Done = 1'b0;
  endtask

  task automatic check_reply(input string tag, input logic [7:0] exp, input int base);
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_cnt"},  64'(tx_pulses - base), 64'd1);
    chk({tag, "_lat"},  64'(last_tx_cyc - rx_cyc), 64'd2);
    chk({tag, "_byte"}, {56'd0, last_tx_byte}, {56'd0, exp});
    chk({tag, "_hold"}, {56'd0, o_Tx_Byte}, {56'd0, exp});
  endtask

  task automatic do_read(input string tag, input logic [7:0] cmd, input logic [7:0] exp);
    int base;
    base = tx_pulses;
    rx(cmd);
    check_reply(tag, exp, base);
    repeat (8) @(negedge clk);
    tx_done();
  endtask

  task automatic do_write(input string tag, input logic [7:0] cmd, input logic [7:0] data,
                          input logic [40:0] exp_regs);
    int base;
    base = tx_pulses;
    rx(cmd);
    @(negedge clk);
    rx(data);
    #1;
    chk({tag, "_regs"}, {23'd0, regs_v}, {23'd0, exp_regs});
    check_reply(tag, 8'h06, base);
    tx_done();
  endtask

  // Directed stimulus, one step after another.
  initial begin
    i_rstn    = 1'b0;
    i_Rx_DV   = 1'b0;
    i_Rx_Byte = 8'h00;
    i_Tx_Done = 1'b0;
    i_status  = 8'hA5;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", {13'd0, outs_v}, 64'd0);
    @(negedge clk);
    i_rstn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("post_reset_outs", {13'd0, outs_v}, 64'd0);

    do_read("rd_id", 8'h07, 8'h45);

    do_write("wr_depth_lo", 8'h82, 8'h34, {8'h00, 8'h00, 16'h0034, 8'h00, 1'b0});
    do_write("wr_depth_hi", 8'h83, 8'h12, {8'h00, 8'h00, 16'h1234, 8'h00, 1'b0});
    chk("precap_depth", {48'd0, o_precap_depth}, 64'h1234);
    do_read("rd_depth_hi", 8'h03, 8'h12);

    s0 = start_pulses;
    do_write("wr_enable", 8'h85, 8'h03, {8'h00, 8'h00, 16'h1234, 8'h00, 1'b1});
    chk("start_cnt", 64'(start_pulses - s0), 64'd1);
    chk("start_lat", 64'(last_start_cyc - rx_cyc), 64'd1);
    do_read("rd_enable", 8'h05, 8'h01);

    // Write command with no data: the byte arriving T cycles later is a new command.
    p0 = tx_pulses;
    rx(8'h81);
    repeat (T - 2) @(negedge clk);
    rx(8'h06);
    check_reply("timeout_rd_status", 8'hA5, p0);
    chk("timeout_trig_type", {56'd0, o_trig_type}, 64'd0);
    chk("timeout_regs", {23'd0, regs_v}, {23'd0, 8'h00, 8'h00, 16'h1234, 8'h00, 1'b1});
    tx_done();

    // Data byte one cycle before the timeout is still accepted.
    p0 = tx_pulses;
    rx(8'h84);
    repeat (T - 3) @(negedge clk);
    rx(8'h07);
    check_reply("late_data_ack", 8'h06, p0);
    chk("late_data_clk_div", {56'd0, o_clk_div}, 64'h07);
    tx_done();

    do_write("wr_chan", 8'h80, 8'h5A, {8'h5A, 8'h00, 16'h1234, 8'h07, 1'b1});
    do_write("wr_ro_status", 8'h86, 8'hFF, {8'h5A, 8'h00, 16'h1234, 8'h07, 1'b1});

    do_read("invalid_48", 8'h48, 8'hEE);
    do_read("invalid_c8", 8'hC8, 8'hEE);
    do_read("rd_after_c8", 8'h04, 8'h07);
    chk("invalid_regs", {23'd0, regs_v}, {23'd0, 8'h5A, 8'h00, 16'h1234, 8'h07, 1'b1});

    // A write command during WAIT_DONE must be dropped.
    p0 = tx_pulses;
    rx(8'h07);
    check_reply("rd_drop", 8'h45, p0);
    rx(8'h80);
    repeat (5) @(negedge clk);
    #1;
    chk("drop_no_extra", 64'(tx_pulses - p0), 64'd1);
    tx_done();
    do_read("rd_chan_after_drop", 8'h00, 8'h5A);

    // Rx byte coinciding with Tx_Done is also dropped.
    p0 = tx_pulses;
    rx(8'h07);
    check_reply("rd_coincide", 8'h45, p0);
    @(negedge clk);
    i_Tx_Done = 1'b1;
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = 8'h01;
    @(negedge clk);
    i_Tx_Done = 1'b0;
    i_Rx_DV   = 1'b0;
    i_Rx_Byte = 8'h00;
    repeat (5) @(negedge clk);
    #1;
    chk("coincide_no_reply", 64'(tx_pulses - p0), 64'd1);
    do_read("rd_type_after_coincide", 8'h01, 8'h00);

    // Reset while waiting for Tx_Done.
    p0 = tx_pulses;
    rx(8'h00);
    check_reply("rd_pre_rst", 8'h5A, p0);
    @(negedge clk);
    i_rstn = 1'b0;
    #1;
    chk("rst_wait_done_outs", {13'd0, outs_v}, 64'd0);
    repeat (2) @(negedge clk);
    i_rstn = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("rst_wait_done_no_tx", 64'(tx_pulses - p0), 64'd1);

    // Reset while waiting for a data byte.
    do_write("wr_chan2", 8'h80, 8'h5A, {8'h5A, 8'h00, 16'h0000, 8'h00, 1'b0});
    p0 = tx_pulses;
    rx(8'h80);
    @(negedge clk);
    i_rstn = 1'b0;
    #1;
    chk("rst_wait_data_outs", {13'd0, outs_v}, 64'd0);
    repeat (2) @(negedge clk);
    i_rstn = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("rst_wait_data_no_tx", 64'(tx_pulses - p0), 64'd0);

    do_read("rd_id_final", 8'h07, 8'h45);
    chk("no_back_to_back_dv", 64'(b2b), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
